arm_fetch_decode: RTL and testbench
===================================

Name: arm_fetch_decode

Overview:
- Front end of the ARM-subset pipeline: an 8-bit program counter, a byte-addressed instruction ROM, and an IF/ID instruction register.
- A combinational control decoder drives the ID-stage control signals from the IF/ID register.
- A bubble multiplexer can force every control output to zero (NOP) for hazard handling.
- Outputs feed the ID/EX pipeline register.

Parameters:
- ROM_BYTES, 256, instruction memory size in bytes (address width fixed at 8).
- PC_STEP, 4, PC increment per enabled cycle.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- pc_en  in  1  PC update enable.
- ifid_en  in  1  IF/ID register load enable.
- nop_sel  in  1  bubble select; 1 forces all control outputs to 0.
- load_we  in  1  ROM preload write strobe.
- load_addr  in  8  ROM preload byte address.
- load_data  in  8  ROM preload byte.
- pc  out  8  current program counter.
- instruction  out  32  IF/ID register contents.
- alu_op  out  4  ALU operation.
- id_load  out  1  load instruction.
- id_mem_write  out  1  memory write (store).
- id_am  out  2  addressing mode.
- store_cc  out  1  update condition codes.
- id_b  out  1  branch.
- id_bl  out  1  branch with link.
- id_mem_size  out  1  1 = byte access, 0 = word access.
- id_mem_e  out  1  memory access enable.
- rf_e  out  1  register-file write enable.

Behaviour:
- Reset: on a clk edge with reset=0, pc<=0 and instruction<=0. All control outputs are then 0, because a zero word decodes as NOP. ROM contents are not reset.
- PC: on each edge with reset=1 and pc_en=1, pc<=pc+4 modulo 256 (252 wraps to 0). pc_en=0 holds pc.
- ROM read is combinational and big-endian: word = {M[pc], M[pc+1], M[pc+2], M[pc+3]}, with byte addresses taken modulo 256.
- ROM write: on a clk edge with load_we=1, M[load_addr]<=load_data. This works regardless of reset. A write becomes visible to the combinational read after that edge.
- IF/ID: on an edge with reset=1 and ifid_en=1, instruction<=ROM word at the current pc. Fetch-to-decode latency is 1 cycle.
- The decoder is purely combinational on instruction. The condition field [31:28] is ignored.
- Defaults for every control signal are 0. An instruction of 32'h0 is NOP: all outputs 0.
- Data processing ([27:26]=00, word nonzero):
  - alu_op = [24:21].
  - store_cc = [20], forced to 1 for opcodes 1000–1011.
  - rf_e = 1 except for opcodes 1000–1011 (TST, TEQ, CMP, CMN).
  - id_am = 00 if [25]=1 (rotated immediate), else 11 (shifted register).
- Load/store ([27:26]=01):
  - id_mem_e = 1.
  - id_load = [20]; id_mem_write = ~[20]; rf_e = [20].
  - id_mem_size = [22].
  - alu_op = 0100 (ADD) if [23]=1, else 0010 (SUB).
  - id_am = 01 if [25]=0 (12-bit immediate offset), else 11 (register offset).
  - store_cc = 0.
- Branch ([27:25]=101):
  - id_b = 1; id_bl = [24]; rf_e = [24].
  - alu_op = 0100.
- Other encodings ([27:25]=100 or 11x) decode as NOP.
- Bubble mux: nop_sel=0 passes decoder outputs unchanged. nop_sel=1 drives all ten control outputs to 0. The mux is combinational and same-cycle, with no effect on pc or instruction.

Decomposition:
- Shared package holds:
  - the opcode constants AND..MVN (0000–1111);
  - the AM encodings: AM_IMM=00, AM_LS_IMM=01, AM_REG=11;
  - the instruction-class field positions;
  - a packed control struct of the ten signals.
- One sub-module, arm_ctrl_decoder, holds the combinational decode.
- PC, ROM, IF/ID register and bubble mux live in the top module.

Test Plan:
1. Reset:
   - Stimulus: hold reset=0 for 2 edges.
   - Required: pc=0, instruction=0, all control outputs 0.
   - Then release with pc_en=1: pc = 4, 8, 12 on successive edges.
2. Preload and fetch ADD:
   - Stimulus: preload bytes E0,81,00,02 (ADD R0,R1,R2) at addresses 0..3; fetch.
   - Required: one edge after reset release, instruction=E0810002, alu_op=0100, rf_e=1, id_am=11, store_cc=0.
3. CMP immediate and LDRB:
   - Stimulus: CMP R1,#5 (E3510005).
   - Required: alu_op=1010, rf_e=0, store_cc=1, id_am=00.
   - Stimulus: LDRB R0,[R1,#-4] (E5510004).
   - Required: id_mem_e=1, id_load=1, id_mem_size=1, alu_op=0010, id_am=01, rf_e=1.
4. STR and BL:
   - Stimulus: STR (E5810000).
   - Required: id_mem_write=1, id_load=0, rf_e=0.
   - Stimulus: BL (EB000003).
   - Required: id_b=1, id_bl=1, rf_e=1.
5. Bubble mux:
   - Stimulus: hold ADD in IF/ID, raise nop_sel=1.
   - Required: all control outputs 0 in the same cycle.
   - Stimulus: lower nop_sel to 0.
   - Required: ADD decode returns.
6. Stall and wrap:
   - Stimulus: pc_en=0 and ifid_en=0 for 3 edges.
   - Required: pc and instruction unchanged.
   - Stimulus: advance from pc=252.
   - Required: next pc=0; the read at 252 returns bytes 252..255.

Source files
------------

// File: rtl/arm_fetch_decode_pkg.sv
// Shared definitions for the ARM-subset front end: opcodes, addressing modes,
// instruction field positions and the ID-stage control bundle.
package arm_fetch_decode_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [1:0] AM_IMM    = 2'b00;
    localparam logic [1:0] AM_LS_IMM = 2'b01;
    localparam logic [1:0] AM_REG    = 2'b11;

    // Instruction field positions
    localparam int unsigned CLASS_HI  = 27;
    localparam int unsigned CLASS_LO  = 26;
    localparam int unsigned IMM_BIT   = 25;
    localparam int unsigned LINK_BIT  = 24;
    localparam int unsigned OP_HI     = 24;
    localparam int unsigned OP_LO     = 21;
    localparam int unsigned UP_BIT    = 23;
    localparam int unsigned BYTE_BIT  = 22;
    localparam int unsigned S_L_BIT   = 20;

    localparam logic [1:0] CLASS_DP = 2'b00;
    localparam logic [1:0] CLASS_LS = 2'b01;
    localparam logic [2:0] CLASS_BR = 3'b101;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       load;
        logic       mem_write;
        logic [1:0] am;
        logic       store_cc;
        logic       b;
        logic       bl;
        logic       mem_size;
        logic       mem_e;
        logic       rf_e;
    } ctrl_t;

    // TST, TEQ, CMP and CMN only set flags and never write a register
    function automatic logic is_compare(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/arm_ctrl_decoder.sv
// Combinational ID-stage control decoder; the condition field is ignored and
// an all-zero word decodes as NOP.
module arm_ctrl_decoder
    import arm_fetch_decode_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl
);

    logic [3:0] opcode;
    logic [1:0] iclass;

    assign opcode = instruction[OP_HI:OP_LO];
    assign iclass = instruction[CLASS_HI:CLASS_LO];

    always_comb begin
        ctrl = '0;
        if (instruction != 32'h0) begin
            if (iclass == CLASS_DP) begin
                ctrl.alu_op   = opcode;
                ctrl.store_cc = instruction[S_L_BIT] | is_compare(opcode);
                ctrl.rf_e     = ~is_compare(opcode);
                ctrl.am       = instruction[IMM_BIT] ? AM_IMM : AM_REG;
            end else if (iclass == CLASS_LS) begin
                ctrl.mem_e     = 1'b1;
                ctrl.load      = instruction[S_L_BIT];
                ctrl.mem_write = ~instruction[S_L_BIT];
                ctrl.rf_e      = instruction[S_L_BIT];
                ctrl.mem_size  = instruction[BYTE_BIT];
                ctrl.alu_op    = instruction[UP_BIT] ? OP_ADD : OP_SUB;
                ctrl.am        = instruction[IMM_BIT] ? AM_REG : AM_LS_IMM;
            end else if (instruction[CLASS_HI:IMM_BIT] == CLASS_BR) begin
                ctrl.b      = 1'b1;
                ctrl.bl     = instruction[LINK_BIT];
                ctrl.rf_e   = instruction[LINK_BIT];
                ctrl.alu_op = OP_ADD;
            end
        end
    end

endmodule

// File: rtl/arm_fetch_decode.sv
// Pipeline front end: PC, byte-wide big-endian instruction ROM with preload port,
// IF/ID register, control decoder and hazard bubble mux.
module arm_fetch_decode
    import arm_fetch_decode_pkg::*;
#(
    parameter int unsigned ROM_BYTES = 256,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_en,
    input  logic        ifid_en,
    input  logic        nop_sel,
    input  logic        load_we,
    input  logic [7:0]  load_addr,
    input  logic [7:0]  load_data,
    output logic [7:0]  pc,
    output logic [31:0] instruction,
    output logic [3:0]  alu_op,
    output logic        id_load,
    output logic        id_mem_write,
    output logic [1:0]  id_am,
    output logic        store_cc,
    output logic        id_b,
    output logic        id_bl,
    output logic        id_mem_size,
    output logic        id_mem_e,
    output logic        rf_e
);

    localparam logic [7:0] PcInc = 8'(PC_STEP);

    logic [7:0]  mem [ROM_BYTES];
    logic [7:0]  pc_q;
    logic [31:0] instr_q;
    logic [31:0] rom_word;
    ctrl_t       ctrl_dec;
    ctrl_t       ctrl_out;

    // Preload port is deliberately independent of reset
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    // 8-bit adds wrap byte addresses modulo 256
    assign rom_word = {mem[pc_q], mem[pc_q + 8'd1], mem[pc_q + 8'd2], mem[pc_q + 8'd3]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= 8'h00;
            instr_q <= 32'h0;
        end else begin
            if (pc_en) begin
                pc_q <= pc_q + PcInc;
            end
            if (ifid_en) begin
                instr_q <= rom_word;
            end
        end
    end

    arm_ctrl_decoder u_decoder (
        .instruction (instr_q),
        .ctrl        (ctrl_dec)
    );

    assign ctrl_out = nop_sel ? '0 : ctrl_dec;

    assign pc           = pc_q;
    assign instruction  = instr_q;
    assign alu_op       = ctrl_out.alu_op;
    assign id_load      = ctrl_out.load;
    assign id_mem_write = ctrl_out.mem_write;
    assign id_am        = ctrl_out.am;
    assign store_cc     = ctrl_out.store_cc;
    assign id_b         = ctrl_out.b;
    assign id_bl        = ctrl_out.bl;
    assign id_mem_size  = ctrl_out.mem_size;
    assign id_mem_e     = ctrl_out.mem_e;
    assign rf_e         = ctrl_out.rf_e;

endmodule

// File: tb/tb_arm_fetch_decode.sv
// Directed bench for arm_fetch_decode: reset, fetch/decode of a short program,
// bubble mux, stall and PC wrap.
module tb_arm_fetch_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en;
    logic        ifid_en;
    logic        nop_sel;
    logic        load_we;
    logic [7:0]  load_addr;
    logic [7:0]  load_data;
    logic [7:0]  pc;
    logic [31:0] instruction;
    logic [3:0]  alu_op;
    logic        id_load;
    logic        id_mem_write;
    logic [1:0]  id_am;
    logic        store_cc;
    logic        id_b;
    logic        id_bl;
    logic        id_mem_size;
    logic        id_mem_e;
    logic        rf_e;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    arm_fetch_decode dut (
        .clk          (clk),
        .reset        (reset),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .nop_sel      (nop_sel),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .pc           (pc),
        .instruction  (instruction),
        .alu_op       (alu_op),
        .id_load      (id_load),
        .id_mem_write (id_mem_write),
        .id_am        (id_am),
        .store_cc     (store_cc),
        .id_b         (id_b),
        .id_bl        (id_bl),
        .id_mem_size  (id_mem_size),
        .id_mem_e     (id_mem_e),
        .rf_e         (rf_e)
    );

    // Packed as {alu_op, load, mem_write, am, store_cc, b, bl, mem_size, mem_e, rf_e}
    logic [13:0] ctrl_obs;
    assign ctrl_obs = {alu_op, id_load, id_mem_write, id_am, store_cc, id_b, id_bl,
                       id_mem_size, id_mem_e, rf_e};

    localparam logic [13:0] C_NOP  = 14'b0000_0_0_00_0_0_0_0_0_0;
    localparam logic [13:0] C_ADD  = 14'b0100_0_0_11_0_0_0_0_0_1;
    localparam logic [13:0] C_CMP  = 14'b1010_0_0_00_1_0_0_0_0_0;
    localparam logic [13:0] C_LDRB = 14'b0010_1_0_01_0_0_0_1_1_1;
    localparam logic [13:0] C_STR  = 14'b0100_0_1_01_0_0_0_0_1_0;
    localparam logic [13:0] C_BL   = 14'b0100_0_0_00_0_1_1_0_0_1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] addr, input logic [31:0] w);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            load_we   = 1'b1;
            load_addr = addr + 8'(i);
            load_data = v[31:24];
            v = v << 8;
            tick();
        end
        load_we = 1'b0;
    endtask

    initial begin
        reset = 1'b0; pc_en = 1'b1; ifid_en = 1'b1; nop_sel = 1'b0;
        load_we = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        tick();
        tick();
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_instr", instruction, 32'h0);
        check("reset_ctrl", 32'(ctrl_obs), 32'(C_NOP));

        // Preload while still in reset; writes must land regardless
        load_word(8'd0, 32'hE081_0002);
        load_word(8'd4, 32'hE351_0005);
        load_word(8'd8, 32'hE551_0004);
        load_word(8'd12, 32'hE581_0000);
        load_word(8'd16, 32'hEB00_0003);
        load_word(8'd252, 32'h1122_3344);
        check("reset_hold_pc", 32'(pc), 32'h0);

        reset = 1'b1;
        tick();
        check("pc_4", 32'(pc), 32'd4);
        check("add_instr", instruction, 32'hE081_0002);
        check("add_ctrl", 32'(ctrl_obs), 32'(C_ADD));
        tick();
        check("pc_8", 32'(pc), 32'd8);
        check("cmp_instr", instruction, 32'hE351_0005);
        check("cmp_ctrl", 32'(ctrl_obs), 32'(C_CMP));
        tick();
        check("pc_12", 32'(pc), 32'd12);
        check("ldrb_ctrl", 32'(ctrl_obs), 32'(C_LDRB));
        tick();
        check("str_ctrl", 32'(ctrl_obs), 32'(C_STR));
        tick();
        check("bl_instr", instruction, 32'hEB00_0003);
        check("bl_ctrl", 32'(ctrl_obs), 32'(C_BL));

        // Reload ADD into IF/ID with the PC held at 0
        reset = 1'b0;
        tick();
        reset = 1'b1; pc_en = 1'b0;
        tick();
        check("refetch_add", instruction, 32'hE081_0002);
        nop_sel = 1'b1;
        #1;
        check("bubble_ctrl", 32'(ctrl_obs), 32'(C_NOP));
        check("bubble_instr", instruction, 32'hE081_0002);
        nop_sel = 1'b0;
        #1;
        check("unbubble_ctrl", 32'(ctrl_obs), 32'(C_ADD));

        ifid_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("stall_pc", 32'(pc), 32'h0);
        check("stall_instr", instruction, 32'hE081_0002);

        pc_en = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        check("pc_252", 32'(pc), 32'd252);
        check("stall_instr2", instruction, 32'hE081_0002);
        ifid_en = 1'b1;
        tick();
        check("wrap_pc", 32'(pc), 32'h0);
        check("wrap_instr", instruction, 32'h1122_3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
